// File: rtl/debug_trace_capture.sv
// Debug trace probe: records probe words into a circular buffer once armed,
// freezes the buffer post_count samples after a masked-compare trigger,
// and unloads the frozen trace serially (oldest word first, LSB first).
module debug_trace_capture #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] probe,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [AW-1:0]    post_count,
  input  logic             arm,
  output logic             armed,
  output logic             triggered,
  output logic             done,
  output logic [AW:0]      fill,
  output logic [AW-1:0]    trig_idx,
  input  logic             ser_load,
  input  logic             ser_shift,
  output logic             tdo
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [AW-1:0]    trig_idx_q, trig_idx_d;
  logic [AW-1:0]    post_left_q, post_left_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;
  logic             hit;
  logic [AW:0]      fill_inc;
  logic [AW-1:0]    rd_next;

  // Next-state: capture FSM, write pointer/fill tracking, readout pointer and shift register.
  // post_count is only AW bits wide, so it can never exceed DEPTH-1; the trigger
  // sample is therefore never overwritten by post-trigger samples.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    trig_idx_d  = trig_idx_q;
    post_left_d = post_left_q;
    rd_ptr_d    = rd_ptr_q;
    shreg_d     = shreg_q;
    wr_en       = 1'b0;

    hit      = ~|((probe ^ trig_value) & trig_mask);
    fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
    // Readout wraps modulo fill; with a full buffer this is the natural pointer wrap.
    rd_next  = (({1'b0, rd_ptr_q} + 1'b1) == fill_q) ? '0 : rd_ptr_q + 1'b1;

    if (arm) begin
      // Restart from any state; the arm-cycle probe value is not recorded.
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      fill_d   = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          fill_d   = fill_inc;
          if (hit) begin
            trig_idx_d = wr_ptr_q;
            if (post_count == '0) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_POST;
              post_left_d = post_count;
            end
          end
        end
        S_POST: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          fill_d   = fill_inc;
          if (post_left_q == AW'(1)) begin
            state_d = S_DONE;
          end else begin
            post_left_d = post_left_q - 1'b1;
          end
        end
        default: ;
      endcase
    end

    // On entry to DONE, point readout at the oldest sample.
    if (state_d == S_DONE && state_q != S_DONE) begin
      rd_ptr_d = (fill_d != FULL) ? '0 : wr_ptr_d;
    end

    // Serial unload: a valid load beats a shift in the same cycle.
    if (ser_load && !arm && state_q == S_DONE && fill_q != '0) begin
      shreg_d  = mem[rd_ptr_q];
      rd_ptr_d = rd_next;
    end else if (ser_shift) begin
      shreg_d = shreg_q >> 1;
    end
  end

  // Control and status registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      trig_idx_q  <= '0;
      post_left_q <= '0;
      rd_ptr_q    <= '0;
      shreg_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      trig_idx_q  <= trig_idx_d;
      post_left_q <= post_left_d;
      rd_ptr_q    <= rd_ptr_d;
      shreg_q     <= shreg_d;
    end
  end

  // Trace buffer RAM; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= probe;
    end
  end

  assign armed     = (state_q == S_ARMED);
  assign triggered = (state_q == S_POST) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign fill      = fill_q;
  assign trig_idx  = trig_idx_q;
  assign tdo       = shreg_q[0];

endmodule
